// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two requesters.
// Registered result carries a tag and has back-pressure. Define ADDARB_CHAIN_EN to get per-requester saved carries.
module add_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] In1_0,
  input  logic [WIDTH-1:0] In2_0,
  input  logic [WIDTH-1:0] In1_1,
  input  logic [WIDTH-1:0] In2_1,
  input  logic             Cin0,
  input  logic             Cin1,
  input  logic             Chain0,
  input  logic             Chain1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Tag,
  output logic             Valid,
  input  logic             ResRdy
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             tag_q, tag_d;
  logic             last_q, last_d;

  logic             slot_free_c;
  logic             accept_c;
  logic             win_c;
  logic [WIDTH-1:0] op_a_c, op_b_c;
  logic             cin_eff_c;
  logic [SUM_W-1:0] add_c;

  // Grants depend only on requests, slot state and the round-robin pointer.
  assign slot_free_c = !valid_q || ResRdy;
  assign Gnt0 = rst_n && slot_free_c && Req0 && (!Req1 || last_q);
  assign Gnt1 = rst_n && slot_free_c && Req1 && (!Req0 || !last_q);
  assign accept_c = Gnt0 || Gnt1;
  assign win_c    = Gnt1;

  assign op_a_c = win_c ? In1_1 : In1_0;
  assign op_b_c = win_c ? In2_1 : In2_0;

`ifdef ADDARB_CHAIN_EN
  logic carry0_q, carry0_d;
  logic carry1_q, carry1_d;

  assign cin_eff_c = win_c ? (Chain1 ? carry1_q : Cin1)
                           : (Chain0 ? carry0_q : Cin0);

  always_comb begin
    carry0_d = carry0_q;
    carry1_d = carry1_q;
    if (accept_c) begin
      if (win_c) carry1_d = add_c[WIDTH];
      else       carry0_d = add_c[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
    end else begin
      carry0_q <= carry0_d;
      carry1_q <= carry1_d;
    end
  end
`else
  logic unused_chain;
  assign unused_chain = Chain0 ^ Chain1;
  assign cin_eff_c = win_c ? Cin1 : Cin0;
`endif

  assign add_c = SUM_W'(op_a_c) + SUM_W'(op_b_c) + SUM_W'(cin_eff_c);

  // A new result may overwrite one that is being drained in the same cycle.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    tag_d   = tag_q;
    last_d  = last_q;
    if (accept_c) begin
      valid_d = 1'b1;
      sum_d   = add_c[WIDTH-1:0];
      cout_d  = add_c[WIDTH];
      tag_d   = win_c;
      last_d  = win_c;
    end else if (valid_q && ResRdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      tag_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign Tag   = tag_q;
  assign Valid = valid_q;

endmodule
